clk_set_ctrl: RTL and testbench



---
 rtl/clk_set_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clk_set_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_set_ctrl.sv
// Key-driven time-setting controller: turns mode/shift/inc pulses into the clock
// generator's work_en/set_pos/set_data/set_flag interface plus a blink mask.
module clk_set_ctrl #(
  parameter logic [25:0] CNT_1S_MAX   = 26'd49_999_999,
  parameter logic [24:0] CNT_HALF_MAX = 25'd24_999_999,
  parameter logic [3:0]  TIMEOUT_S    = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_shift,
  input  logic       key_inc,
  output logic       work_en,
  output logic [2:0] set_pos,
  output logic [3:0] set_data,
  output logic       set_flag,
  output logic [5:0] blink
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SET = 2'd1, ST_EXIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            work_en_q, work_en_d;
  logic [2:0]      set_pos_q, set_pos_d;
  logic [3:0]      set_data_q, set_data_d;
  logic            set_flag_q, set_flag_d;
  logic [5:0]      blink_q, blink_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [25:0]     cnt_1s_q, cnt_1s_d;
  logic [24:0]     cnt_half_q, cnt_half_d;
  logic            phase_q, phase_d;
  logic [3:0]      idle_q, idle_d;

  logic       in_set_s, mode_s, shift_s, inc_s, any_key_s, sec_tick_s, timeout_s;
  logic [3:0] cur_dig_s, inc_val_s;
  logic [2:0] next_pos_s;

  // Hour digits limit each other so the result can never exceed 23.
  function automatic logic [3:0] digit_limit(input logic [2:0] pos, input logic [3:0] d4,
                                             input logic [3:0] d5);
    case (pos)
      3'd0, 3'd2: digit_limit = 4'd9;
      3'd1, 3'd3: digit_limit = 4'd5;
      3'd4:       digit_limit = (d5 == 4'd2) ? 4'd3 : 4'd9;
      3'd5:       digit_limit = (d4 > 4'd3) ? 4'd1 : 4'd2;
      default:    digit_limit = 4'd9;
    endcase
  endfunction

  always_comb begin
    in_set_s   = (state_q == ST_SET);
    any_key_s  = key_mode | key_shift | key_inc;
    mode_s     = in_set_s & key_mode;
    shift_s    = in_set_s & ~key_mode & key_shift;
    inc_s      = in_set_s & ~key_mode & ~key_shift & key_inc;
    sec_tick_s = in_set_s && (cnt_1s_q == CNT_1S_MAX);
    timeout_s  = in_set_s && !any_key_s && sec_tick_s && (idle_q == TIMEOUT_S - 4'd1);
    cur_dig_s  = dig_q[set_pos_q];
    inc_val_s  = (cur_dig_s == digit_limit(set_pos_q, dig_q[4], dig_q[5])) ? 4'd0
                                                                           : cur_dig_s + 4'd1;
    next_pos_s = (set_pos_q == 3'd5) ? 3'd0 : set_pos_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (key_mode) state_d = ST_SET;
      ST_SET:  if (mode_s || timeout_s) state_d = ST_EXIT;
      ST_EXIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Timers only run in SET; any key restarts both the idle count and the blink phase.
  always_comb begin
    cnt_1s_d   = 26'd0;
    cnt_half_d = 25'd0;
    phase_d    = 1'b1;
    idle_d     = 4'd0;
    if (in_set_s) begin
      cnt_1s_d = (cnt_1s_q == CNT_1S_MAX) ? 26'd0 : cnt_1s_q + 26'd1;
      if (any_key_s) begin
        idle_d = 4'd0;
      end else if (sec_tick_s) begin
        idle_d = idle_q + 4'd1;
      end else begin
        idle_d = idle_q;
      end
      if (any_key_s) begin
        cnt_half_d = 25'd0;
        phase_d    = 1'b1;
      end else if (cnt_half_q == CNT_HALF_MAX) begin
        cnt_half_d = 25'd0;
        phase_d    = ~phase_q;
      end else begin
        cnt_half_d = cnt_half_q + 25'd1;
        phase_d    = phase_q;
      end
    end
  end

  always_comb begin
    dig_d      = dig_q;
    set_pos_d  = set_pos_q;
    set_data_d = set_data_q;
    set_flag_d = 1'b0;
    if (state_q == ST_RUN && key_mode) begin
      dig_d      = '0;
      set_pos_d  = 3'd0;
      set_data_d = 4'd0;
    end else if (shift_s) begin
      set_pos_d  = next_pos_s;
      set_data_d = dig_q[next_pos_s];
    end else if (inc_s) begin
      dig_d[set_pos_q] = inc_val_s;
      set_data_d       = inc_val_s;
      set_flag_d       = 1'b1;
    end else begin
      set_flag_d = 1'b0;
    end
    work_en_d = (state_d == ST_RUN);
    blink_d   = (state_d == ST_SET && phase_d) ? (6'b000001 << set_pos_d) : 6'b000000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_en_q  <= 1'b1;
      set_pos_q  <= 3'd0;
      set_data_q <= 4'd0;
      set_flag_q <= 1'b0;
      blink_q    <= 6'd0;
      dig_q      <= '0;
      cnt_1s_q   <= 26'd0;
      cnt_half_q <= 25'd0;
      phase_q    <= 1'b1;
      idle_q     <= 4'd0;
    end else begin
      work_en_q  <= work_en_d;
      set_pos_q  <= set_pos_d;
      set_data_q <= set_data_d;
      set_flag_q <= set_flag_d;
      blink_q    <= blink_d;
      dig_q      <= dig_d;
      cnt_1s_q   <= cnt_1s_d;
      cnt_half_q <= cnt_half_d;
      phase_q    <= phase_d;
      idle_q     <= idle_d;
    end
  end

  assign work_en  = work_en_q;
  assign set_pos  = set_pos_q;
  assign set_data = set_data_q;
  assign set_flag = set_flag_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed bench for clk_set_ctrl with shortened second/half-second periods
// (100 and 50 cycles) so timeout behaviour fits in a short run.
module tb_clk_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode, key_shift, key_inc;
  logic       work_en;
  logic [2:0] set_pos;
  logic [3:0] set_data;
  logic       set_flag;
  logic [5:0] blink;

  int checks = 0;
  int errors = 0;

  clk_set_ctrl #(
    .CNT_1S_MAX  (26'd99),
    .CNT_HALF_MAX(25'd49),
    .TIMEOUT_S   (4'd10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_shift(key_shift),
    .key_inc  (key_inc),
    .work_en  (work_en),
    .set_pos  (set_pos),
    .set_data (set_data),
    .set_flag (set_flag),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m, s, i;
    logic       we;
    logic [2:0] pos;
    logic [3:0] data;
    logic       flag;
    logic [5:0] blk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic s, input logic i, input logic we,
                     input logic [2:0] pos, input logic [3:0] data, input logic flag,
                     input logic [5:0] blk);
    vec_t v;
    v.m = m; v.s = s; v.i = i; v.we = we; v.pos = pos; v.data = data; v.flag = flag; v.blk = blk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock: drive keys on the falling edge, sample just after the rising edge
  task automatic step(input logic m, input logic s, input logic i);
    @(negedge clk);
    key_mode = m; key_shift = s; key_inc = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_hi;
    logic saw_flag, saw_we0, saw_blink;

    rst = 1'b1; key_mode = 1'b0; key_shift = 1'b0; key_inc = 1'b0;

    // Table: {mode, shift, inc} -> {work_en, set_pos, set_data, set_flag, blink}
    add(0,0,0, 1,3'd0,4'd0,0,6'h00);
    add(1,0,0, 0,3'd0,4'd0,0,6'h01);
    add(0,0,1, 0,3'd0,4'd1,1,6'h01); add(0,0,0, 0,3'd0,4'd1,0,6'h01);
    add(0,0,1, 0,3'd0,4'd2,1,6'h01); add(0,0,0, 0,3'd0,4'd2,0,6'h01);
    add(0,0,1, 0,3'd0,4'd3,1,6'h01); add(0,0,0, 0,3'd0,4'd3,0,6'h01);
    add(0,1,0, 0,3'd1,4'd0,0,6'h02);
    add(0,0,1, 0,3'd1,4'd1,1,6'h02); add(0,0,1, 0,3'd1,4'd2,1,6'h02);
    add(0,0,1, 0,3'd1,4'd3,1,6'h02); add(0,0,1, 0,3'd1,4'd4,1,6'h02);
    add(0,0,1, 0,3'd1,4'd5,1,6'h02); add(0,0,1, 0,3'd1,4'd0,1,6'h02);
    add(0,0,1, 0,3'd1,4'd1,1,6'h02); add(0,0,0, 0,3'd1,4'd1,0,6'h02);
    add(0,1,0, 0,3'd2,4'd0,0,6'h04); add(0,1,0, 0,3'd3,4'd0,0,6'h08);
    add(0,1,0, 0,3'd4,4'd0,0,6'h10); add(0,1,0, 0,3'd5,4'd0,0,6'h20);
    add(0,1,0, 0,3'd0,4'd3,0,6'h01);
    // hours: d5 -> 2, then d4 limited to 3
    add(0,1,0, 0,3'd1,4'd1,0,6'h02); add(0,1,0, 0,3'd2,4'd0,0,6'h04);
    add(0,1,0, 0,3'd3,4'd0,0,6'h08); add(0,1,0, 0,3'd4,4'd0,0,6'h10);
    add(0,1,0, 0,3'd5,4'd0,0,6'h20);
    add(0,0,1, 0,3'd5,4'd1,1,6'h20); add(0,0,1, 0,3'd5,4'd2,1,6'h20);
    add(0,0,0, 0,3'd5,4'd2,0,6'h20);
    add(0,1,0, 0,3'd0,4'd3,0,6'h01); add(0,1,0, 0,3'd1,4'd1,0,6'h02);
    add(0,1,0, 0,3'd2,4'd0,0,6'h04); add(0,1,0, 0,3'd3,4'd0,0,6'h08);
    add(0,1,0, 0,3'd4,4'd0,0,6'h10);
    add(0,0,1, 0,3'd4,4'd1,1,6'h10); add(0,0,1, 0,3'd4,4'd2,1,6'h10);
    add(0,0,1, 0,3'd4,4'd3,1,6'h10); add(0,0,1, 0,3'd4,4'd0,1,6'h10);
    add(0,0,1, 0,3'd4,4'd1,1,6'h10);
    add(1,0,0, 0,3'd4,4'd1,0,6'h00); add(0,0,0, 1,3'd4,4'd1,0,6'h00);
    // RUN ignores shift and inc
    add(0,1,0, 1,3'd4,4'd1,0,6'h00); add(0,0,1, 1,3'd4,4'd1,0,6'h00);
    // re-entry clears shadows; d4 = 7 limits d5 to 1
    add(1,0,0, 0,3'd0,4'd0,0,6'h01);
    add(0,1,0, 0,3'd1,4'd0,0,6'h02); add(0,1,0, 0,3'd2,4'd0,0,6'h04);
    add(0,1,0, 0,3'd3,4'd0,0,6'h08); add(0,1,0, 0,3'd4,4'd0,0,6'h10);
    for (int k = 1; k <= 7; k++) add(0,0,1, 0,3'd4,k[3:0],1,6'h10);
    add(0,1,0, 0,3'd5,4'd0,0,6'h20);
    add(0,0,1, 0,3'd5,4'd1,1,6'h20); add(0,0,1, 0,3'd5,4'd0,1,6'h20);
    // inc then mode on the next cycle: work_en low for two cycles after the strobe
    add(0,0,1, 0,3'd5,4'd1,1,6'h20);
    add(1,0,0, 0,3'd5,4'd1,0,6'h00); add(0,0,0, 1,3'd5,4'd1,0,6'h00);
    // mode+inc together: exit, no strobe
    add(1,0,0, 0,3'd0,4'd0,0,6'h01);
    add(1,0,1, 0,3'd0,4'd0,0,6'h00); add(0,0,0, 1,3'd0,4'd0,0,6'h00);
    // shift+inc together: shift wins, no strobe
    add(1,0,0, 0,3'd0,4'd0,0,6'h01);
    add(0,1,1, 0,3'd1,4'd0,0,6'h02);
    add(1,0,0, 0,3'd1,4'd0,0,6'h00); add(0,0,0, 1,3'd1,4'd0,0,6'h00);

    repeat (3) @(posedge clk);
    #1;
    check("rst_work_en", work_en, 1);
    check("rst_set_pos", set_pos, 0);
    check("rst_set_data", set_data, 0);
    check("rst_set_flag", set_flag, 0);
    check("rst_blink", blink, 0);
    @(negedge clk);
    rst = 1'b0;

    // three idle seconds in RUN
    saw_flag = 1'b0; saw_we0 = 1'b0; saw_blink = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step(0,0,0);
      if (set_flag) saw_flag = 1'b1;
      if (!work_en) saw_we0 = 1'b1;
      if (blink != 6'd0) saw_blink = 1'b1;
    end
    check("idle_run_flag", saw_flag, 0);
    check("idle_run_we_low", saw_we0, 0);
    check("idle_run_blink", saw_blink, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].m, vecs[n].s, vecs[n].i);
      check($sformatf("vec%0d_work_en", n), work_en, vecs[n].we);
      check($sformatf("vec%0d_set_pos", n), set_pos, vecs[n].pos);
      check($sformatf("vec%0d_set_data", n), set_data, vecs[n].data);
      check($sformatf("vec%0d_set_flag", n), set_flag, vecs[n].flag);
      check($sformatf("vec%0d_blink", n), blink, vecs[n].blk);
    end

    // timeout after 10 idle seconds, plus blink phase toggle at half a second
    step(1,0,0);
    check("to_enter_we", work_en, 0);
    first_hi = 0;
    for (int k = 1; k <= 1100; k++) begin
      step(0,0,0);
      if (k == 49) check("blink_on_49", blink, 6'h01);
      if (k == 50) check("blink_off_50", blink, 6'h00);
      if (k == 1000) check("to_exit_we", work_en, 0);
      if (work_en && first_hi == 0) first_hi = k;
      if (first_hi != 0) break;
    end
    check("timeout_cycle", first_hi, 1001);

    // a key at 9 s restarts the idle count
    step(1,0,0);
    check("to2_enter_we", work_en, 0);
    first_hi = 0;
    for (int k = 1; k <= 2100; k++) begin
      if (k == 901) step(0,0,1);
      else step(0,0,0);
      if (k == 1001) check("to2_still_set", work_en, 0);
      if (work_en && first_hi == 0) first_hi = k;
      if (first_hi != 0) break;
    end
    check("timeout_restart_cycle", first_hi, 1901);

    // asynchronous reset in the middle of SET
    step(1,0,0);
    step(0,1,0);
    step(0,1,0);
    check("pre_rst_pos", set_pos, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_we", work_en, 1);
    check("async_rst_pos", set_pos, 0);
    check("async_rst_blink", blink, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0,0,1);
    check("post_rst_we", work_en, 1);
    check("post_rst_flag", set_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
